// File: rtl/rc4_decrypt_message_if.sv
// Handshake and memory bus bundle of the RC4 keystream/XOR stage.
// The master side is the decrypt block; the slave side is the S RAM, message ROM and controller.
interface rc4_decrypt_message_if #(
  parameter int MSG_AW = 5
);
  logic              start;
  logic              finish;
  logic              busy;
  logic [7:0]        s_addr;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic [MSG_AW-1:0] dec_addr;
  logic [7:0]        dec_data;
  logic              dec_wren;

  modport master (
    input  start, s_q, rom_q,
    output finish, busy, s_addr, s_data, s_wren, rom_addr, dec_addr, dec_data, dec_wren
  );

  modport slave (
    output start, s_q, rom_q,
    input  finish, busy, s_addr, s_data, s_wren, rom_addr, dec_addr, dec_data, dec_wren
  );
endinterface

// File: rtl/rc4_decrypt_message.sv
// RC4 PRGA over a preloaded S RAM; XORs each keystream byte with the encrypted ROM
// and writes the plaintext into the decrypted-message RAM, 13 cycles per byte.
//
// state   | meaning
// IDLE    | waiting for start
// INC_I   | i <= i+1
// RD_SI   | present address i to S RAM
// WAIT_SI | hold address i (RAM latency)
// GET_SI  | capture si = S[i], j += si
// RD_SJ   | present address j
// WAIT_SJ | hold address j
// GET_SJ  | capture sj = S[j]
// WR_SI   | S[i] <= sj
// WR_SJ   | S[j] <= si
// RD_F    | present S[si+sj] and rom[k]
// WAIT_F  | hold both addresses
// XOR     | dec[k] <= S[si+sj] ^ rom[k]
// NEXT    | advance k or finish
// DONE    | one-cycle finish pulse
module rc4_decrypt_message #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input logic                   clk,
  input logic                   reset,
  rc4_decrypt_message_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, WAIT_SI, GET_SI, RD_SJ, WAIT_SJ, GET_SJ,
    WR_SI, WR_SJ, RD_F, WAIT_F, XOR_F, NEXT, DONE
  } state_t;

  state_t            state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [MSG_AW-1:0] k;

  // The write data is captured by the RAM at the end of XOR_F, so the combine is taken
  // straight from the read ports; this keeps both 1- and 2-cycle read latency usable.
  assign bus.dec_data = bus.dec_wren ? (bus.s_q ^ bus.rom_q) : 8'h00;

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      i            <= 8'h00;
      j            <= 8'h00;
      k            <= '0;
      si           <= 8'h00;
      sj           <= 8'h00;
      bus.finish   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.s_addr   <= 8'h00;
      bus.s_data   <= 8'h00;
      bus.s_wren   <= 1'b0;
      bus.rom_addr <= '0;
      bus.dec_addr <= '0;
      bus.dec_wren <= 1'b0;
    end else begin
      bus.finish   <= 1'b0;
      bus.busy     <= 1'b1;
      bus.s_data   <= 8'h00;
      bus.s_wren   <= 1'b0;
      bus.dec_addr <= '0;
      bus.dec_wren <= 1'b0;
      case (state)
        IDLE: begin
          bus.s_addr   <= 8'h00;
          bus.rom_addr <= '0;
          if (bus.start) begin
            i     <= 8'h00;
            j     <= 8'h00;
            k     <= '0;
            state <= INC_I;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        INC_I: begin
          i          <= i + 8'd1;
          bus.s_addr <= i + 8'd1;
          state      <= RD_SI;
        end
        RD_SI:   state <= WAIT_SI;
        WAIT_SI: state <= GET_SI;
        GET_SI: begin
          si         <= bus.s_q;
          j          <= j + bus.s_q;
          bus.s_addr <= j + bus.s_q;
          state      <= RD_SJ;
        end
        RD_SJ:   state <= WAIT_SJ;
        WAIT_SJ: state <= GET_SJ;
        GET_SJ: begin
          sj         <= bus.s_q;
          bus.s_addr <= i;
          bus.s_data <= bus.s_q;
          bus.s_wren <= 1'b1;
          state      <= WR_SI;
        end
        WR_SI: begin
          bus.s_addr <= j;
          bus.s_data <= si;
          bus.s_wren <= 1'b1;
          state      <= WR_SJ;
        end
        WR_SJ: begin
          bus.s_addr   <= si + sj;
          bus.rom_addr <= k;
          state        <= RD_F;
        end
        RD_F:   state <= WAIT_F;
        WAIT_F: begin
          bus.dec_addr <= k;
          bus.dec_wren <= 1'b1;
          state        <= XOR_F;
        end
        XOR_F: begin
          bus.s_addr   <= 8'h00;
          bus.rom_addr <= '0;
          state        <= NEXT;
        end
        NEXT: begin
          if (k == MSG_AW'(MSG_LEN - 1)) begin
            bus.finish <= 1'b1;
            state      <= DONE;
          end else begin
            k     <= k + MSG_AW'(1);
            state <= INC_I;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
